// File: rtl/nco_iq_mixer.sv
// nco_iq_mixer: quadrature down-mixer of ADC samples by NCO cos/sin with round, saturate and clip counting
module nco_iq_mixer #(
  parameter int adw   = 16,
  parameter int mpr   = 16,
  parameter int odw   = 18,
  parameter int neg_q = 1,
  parameter int cntw  = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clken,
  input  logic [adw-1:0]  adc_i,
  input  logic            adc_valid,
  input  logic [mpr-1:0]  nco_sin,
  input  logic [mpr-1:0]  nco_cos,
  input  logic            nco_valid,
  input  logic            clr_clip,
  output logic [odw-1:0]  i_o,
  output logic [odw-1:0]  q_o,
  output logic            out_valid,
  output logic            clip_o,
  output logic [cntw-1:0] clip_cnt,
  output logic            mix_active
);
  localparam int pw   = adw + mpr;
  localparam int drop = pw - 1 - odw;
  localparam logic signed [pw:0] rnd  = drop == 0 ? '0 : (pw+1)'(1) << (drop > 0 ? drop - 1 : 0);
  localparam logic signed [pw:0] omax = {{(pw-odw+2){1'b0}}, {(odw-1){1'b1}}};
  localparam logic signed [pw:0] omin = ~omax;
  typedef enum logic [1:0] {idle, run, drain} state_t;
  state_t state, nxt;
  logic [1:0] dcnt;
  logic cap, s1_v, s2_v, clip_n;
  logic [adw-1:0] s1_a;
  logic [mpr-1:0] s1_s, s1_c;
  logic [pw-1:0] s2_i, s2_q, ax, cx, sx, pi_n, pq_m, pq_n;
  logic [odw:0] ri, rq;
  // round half up, then clamp; top bit flags a clamp
  function automatic logic [odw:0] rs(input logic [pw-1:0] p);
    logic signed [pw:0] e;
    e = ($signed({p[pw-1], p}) + rnd) >>> drop;
    return e > omax ? {1'b1, omax[odw-1:0]} : e < omin ? {1'b1, omin[odw-1:0]} : {1'b0, e[odw-1:0]};
  endfunction
  // state register with drain cycle counter
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= idle;
      dcnt  <= 2'd0;
    end else if (clken) begin
      state <= nxt;
      dcnt  <= state == drain ? dcnt + 2'd1 : 2'd0;
    end
  // next state: drain lasts three enabled cycles and ignores nco_valid
  always_comb
    nxt = state == idle ? (nco_valid ? run : idle) :
          state == run  ? (nco_valid ? run : drain) :
          state == drain ? (dcnt == 2'd2 ? idle : drain) : idle;
  // FSM outputs: only RUN captures samples
  always_comb begin
    mix_active = state == run;
    cap        = state == run && adc_valid && nco_valid;
  end
  // signed products via sign-extended operands; low pw bits are exact
  always_comb begin
    ax   = {{mpr{s1_a[adw-1]}}, s1_a};
    cx   = {{adw{s1_c[mpr-1]}}, s1_c};
    sx   = {{adw{s1_s[mpr-1]}}, s1_s};
    pi_n = ax * cx;
    pq_m = ax * sx;
    pq_n = neg_q != 0 ? -pq_m : pq_m;
    ri   = rs(s2_i);
    rq   = rs(s2_q);
    clip_n = s2_v && (ri[odw] || rq[odw]);
  end
  // three-stage pipeline; outputs hold when no valid sample arrives
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      s1_v <= 1'b0;
      s1_a <= '0;
      s1_s <= '0;
      s1_c <= '0;
      s2_v <= 1'b0;
      s2_i <= '0;
      s2_q <= '0;
      out_valid <= 1'b0;
      clip_o <= 1'b0;
      i_o <= '0;
      q_o <= '0;
    end else if (clken) begin
      s1_v <= cap;
      s1_a <= adc_i;
      s1_s <= nco_sin;
      s1_c <= nco_cos;
      s2_v <= s1_v;
      s2_i <= pi_n;
      s2_q <= pq_n;
      out_valid <= s2_v;
      clip_o <= clip_n;
      if (s2_v) begin
        i_o <= ri[odw-1:0];
        q_o <= rq[odw-1:0];
      end
    end
  // saturating clip counter; clear wins and ignores clken
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) clip_cnt <= '0;
    else if (clr_clip) clip_cnt <= '0;
    else if (clken && clip_n && clip_cnt != '1) clip_cnt <= clip_cnt + cntw'(1);
endmodule

// File: tb/tb_nco_iq_mixer.sv
// tb_nco_iq_mixer: directed vectors against an integer-arithmetic model of the mixer
module tb_nco_iq_mixer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, clken = 1'b1, adc_valid = 1'b0, nco_valid = 1'b0, clr_clip = 1'b0;
  logic [15:0] adc_i = '0, nco_sin = '0, nco_cos = '0;
  logic [17:0] i_o, q_o;
  logic out_valid, clip_o, mix_active;
  logic [15:0] clip_cnt;
  int nvec = 0, nerr = 0;

  nco_iq_mixer #(.adw(16), .mpr(16), .odw(18), .neg_q(1), .cntw(16)) dut (
    .clk(clk), .reset_n(reset_n), .clken(clken), .adc_i(adc_i), .adc_valid(adc_valid),
    .nco_sin(nco_sin), .nco_cos(nco_cos), .nco_valid(nco_valid), .clr_clip(clr_clip),
    .i_o(i_o), .q_o(q_o), .out_valid(out_valid), .clip_o(clip_o), .clip_cnt(clip_cnt),
    .mix_active(mix_active)
  );

  task automatic chk(input string nm, input longint act, input longint exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // rounding to 18 bits from a 32-bit product: drop 13 LSBs, half up
  function automatic longint rnd13(input longint p);
    return (p + 4096) >>> 13;
  endfunction
  function automatic longint sat(input longint x);
    return x > 131071 ? 131071 : x < -131072 ? -131072 : x;
  endfunction
  function automatic bit cl(input longint p);
    return sat(rnd13(p)) != rnd13(p);
  endfunction

  // model: 0 idle, 1 run, 2 drain; two-entry delay line before the output
  longint m_i = 0, m_q = 0, m_cnt = 0;
  bit m_v = 0, m_clip = 0;
  int mode = 0, left = 0;
  bit dv[2] = '{0, 0};
  longint da[2] = '{0, 0}, ds[2] = '{0, 0}, dc[2] = '{0, 0};

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_i <= 0; m_q <= 0; m_cnt <= 0; m_v <= 0; m_clip <= 0; mode <= 0; left <= 0;
      dv <= '{0, 0};
    end else begin
      if (clken) begin
        m_v <= dv[1];
        m_clip <= dv[1] && (cl(da[1] * dc[1]) || cl(-(da[1] * ds[1])));
        if (dv[1]) begin
          m_i <= sat(rnd13(da[1] * dc[1]));
          m_q <= sat(rnd13(-(da[1] * ds[1])));
        end
        dv[1] <= dv[0]; da[1] <= da[0]; ds[1] <= ds[0]; dc[1] <= dc[0];
        dv[0] <= mode == 1 && adc_valid && nco_valid;
        da[0] <= longint'($signed(adc_i));
        ds[0] <= longint'($signed(nco_sin));
        dc[0] <= longint'($signed(nco_cos));
        case (mode)
          0: if (nco_valid) mode <= 1;
          1: if (!nco_valid) begin mode <= 2; left <= 3; end
          default: begin left <= left - 1; if (left == 1) mode <= 0; end
        endcase
      end
      if (clr_clip) m_cnt <= 0;
      else if (clken && dv[1] && (cl(da[1] * dc[1]) || cl(-(da[1] * ds[1]))) && m_cnt < 65535)
        m_cnt <= m_cnt + 1;
    end
  end

  // every-cycle comparison against the model
  always @(negedge clk) if (reset_n === 1'b1 || reset_n === 1'b0) begin
    chk("i_o", longint'($signed(i_o)), m_i);
    chk("q_o", longint'($signed(q_o)), m_q);
    chk("out_valid", longint'(out_valid), longint'(m_v));
    chk("clip_o", longint'(clip_o), longint'(m_clip));
    chk("clip_cnt", longint'(clip_cnt), m_cnt);
    chk("mix_active", longint'(mix_active), longint'(mode == 1));
  end

  typedef struct { int a; int c; int s; longint ei; longint eq; } vec_t;
  vec_t vt[7] = '{
    '{-16384, 32767, 0, -65534, 0},
    '{16384, 0, 16384, 0, -32768},
    '{1, 4096, 0, 1, 0},
    '{1, 4095, 0, 0, 0},
    '{-1, 4096, 0, 0, 0},
    '{-1, 4097, 0, -1, 0},
    '{1, 0, -4096, 0, 1}
  };

  initial begin
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // no NCO: nothing may come out
    adc_valid = 1'b1;
    adc_i = 16'h1234;
    repeat (20) @(negedge clk);
    chk("idle_valid", longint'(out_valid), 0);
    chk("idle_active", longint'(mix_active), 0);
    chk("idle_i", longint'(i_o), 0);
    // gain and latency
    nco_valid = 1'b1;
    adc_i = 16'd16384; nco_cos = 16'd32767; nco_sin = 16'd0;
    repeat (3) @(negedge clk);
    chk("lat_early", longint'(out_valid), 0);
    @(negedge clk);
    chk("lat_valid", longint'(out_valid), 1);
    chk("gain_i", longint'($signed(i_o)), 65534);
    chk("gain_q", longint'($signed(q_o)), 0);
    chk("gain_clip", longint'(clip_o), 0);
    // rounding and sign vectors
    foreach (vt[k]) begin
      adc_i = 16'(vt[k].a); nco_cos = 16'(vt[k].c); nco_sin = 16'(vt[k].s);
      repeat (3) @(negedge clk);
      chk("vec_i", longint'($signed(i_o)), vt[k].ei);
      chk("vec_q", longint'($signed(q_o)), vt[k].eq);
    end
    // saturation
    adc_i = 16'h8000; nco_cos = 16'h8000; nco_sin = 16'h8000;
    repeat (3) @(negedge clk);
    chk("sat_i", longint'($signed(i_o)), 131071);
    chk("sat_q", longint'($signed(q_o)), -131072);
    chk("sat_clip", longint'(clip_o), 1);
    chk("sat_cnt1", longint'(clip_cnt), 1);
    @(negedge clk);
    chk("sat_cnt2", longint'(clip_cnt), 2);
    // clken gating with a changing stream
    nco_cos = 16'd20000; nco_sin = 16'hd120;
    for (int i = 0; i < 16; i++) begin
      clken = (i % 2) == 0;
      adc_i = 16'(i * 1000 - 7000);
      @(negedge clk);
    end
    clken = 1'b1;
    repeat (4) @(negedge clk);
    // drain with nco_valid bouncing back during drain
    for (int i = 0; i < 5; i++) begin
      adc_i = 16'(i * 3001 + 11);
      @(negedge clk);
    end
    nco_valid = 1'b0;
    @(negedge clk);
    chk("drain_active", longint'(mix_active), 0);
    @(negedge clk);
    chk("drain_out1", longint'(out_valid), 1);
    nco_valid = 1'b1;
    @(negedge clk);
    chk("drain_out2", longint'(out_valid), 0);
    @(negedge clk);
    chk("drain_idle", longint'(mix_active), 0);
    @(negedge clk);
    chk("restart", longint'(mix_active), 1);
    repeat (4) @(negedge clk);
    // clear while clken is low
    adc_i = 16'h8000; nco_cos = 16'h8000; nco_sin = 16'h0000;
    repeat (5) @(negedge clk);
    clken = 1'b0; clr_clip = 1'b1;
    @(negedge clk);
    chk("clr_noen", longint'(clip_cnt), 0);
    clken = 1'b1; clr_clip = 1'b0;
    // counter saturation
    repeat (65540) @(negedge clk);
    chk("cnt_sat", longint'(clip_cnt), 65535);
    clr_clip = 1'b1;
    @(negedge clk);
    chk("clr_clip_evt", longint'(clip_o), 1);
    chk("clr_prio", longint'(clip_cnt), 0);
    clr_clip = 1'b0;
    @(negedge clk);
    chk("cnt_resume", longint'(clip_cnt), 1);
    // asynchronous reset mid-stream
    #2 reset_n = 1'b0;
    #1;
    chk("rst_i", longint'(i_o), 0);
    chk("rst_q", longint'(q_o), 0);
    chk("rst_valid", longint'(out_valid), 0);
    chk("rst_clip", longint'(clip_o), 0);
    chk("rst_cnt", longint'(clip_cnt), 0);
    chk("rst_active", longint'(mix_active), 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_nopartial", longint'(out_valid), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/nco_iq_mixer.md
Name: nco_iq_mixer

Overview:
- Quadrature down-mixer placed directly downstream of the NCO.
- Multiplies each signed ADC sample by the NCO cosine and sine outputs to produce baseband I and Q samples, which feed the CIC decimators.
- Rounds and saturates products to the decimator input width, and keeps a saturating clip counter for AGC and debug.
- A small control FSM holds the output off until the NCO reports valid data, and drains the pipeline cleanly when NCO valid drops.

Parameters:
adw, 16, ADC sample width (signed)
mpr, 16, NCO sin/cos width (signed); matches NCO magnitude precision
odw, 18, I/Q output width (signed); must satisfy odw <= adw+mpr-1
neg_q, 1, 1: q_o = -(adc*sin); 0: q_o = +(adc*sin)
cntw, 16, clip counter width

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
clken  in  1  clock enable; pipeline and FSM advance only when high
adc_i  in  adw  signed ADC sample
adc_valid  in  1  adc_i valid this cycle
nco_sin  in  mpr  NCO sine sample
nco_cos  in  mpr  NCO cosine sample
nco_valid  in  1  NCO out_valid
clr_clip  in  1  synchronous clip counter clear; acts on any clk edge regardless of clken
i_o  out  odw  in-phase result
q_o  out  odw  quadrature result
out_valid  out  1  i_o/q_o valid
clip_o  out  1  current output sample saturated (I or Q)
clip_cnt  out  cntw  saturating count of clipped output samples
mix_active  out  1  FSM in RUN state

Behaviour:
- Reset (async assert, sync release): all pipeline registers 0; i_o=0, q_o=0, out_valid=0, clip_o=0, clip_cnt=0, mix_active=0; FSM=IDLE.
- When clken=0, no register changes except clip_cnt, which responds to clr_clip.
- FSM (evaluated on clken-qualified edges):
  - IDLE: captures nothing. nco_valid=1 -> RUN.
  - RUN: mix_active=1. Stage-1 valid = adc_valid & nco_valid. nco_valid=0 -> DRAIN.
  - DRAIN: captures nothing (stage-1 valid=0). After 3 enabled cycles (pipeline empty) -> IDLE. If nco_valid returns during DRAIN, it is ignored until IDLE.
- Pipeline: 3 clken-qualified stages. A sample captured at enabled edge N appears on the outputs after enabled edge N+2, i.e. latency 3 enabled cycles. The valid bit travels with the data.
  - S1: register adc_i, nco_sin, nco_cos and valid.
  - S2: signed products pi = adc*cos and pq = adc*sin, width adw+mpr. If neg_q=1, pq is negated; negation cannot overflow at adw+mpr bits.
  - S3: round and saturate.
    - drop = adw+mpr-1-odw.
    - Sign-extend the product by 1 bit, add 2^(drop-1) (round half up; skip the add if drop=0), then arithmetic shift right by drop.
    - Clamp to [-2^(odw-1), 2^(odw-1)-1].
    - clip_o = either channel clamped, qualified by valid.
- Output registers hold their last value when out_valid=0. out_valid is asserted only for valid samples.
- clip_cnt:
  - Increments by 1 per output sample with clip_o=1.
  - Saturates at 2^cntw-1; no wrap.
  - clr_clip has priority: if clear and a clip event coincide, the result is 0 and the event is dropped.
- Reset mid-operation: all state is lost immediately and the FSM returns to IDLE. No partial sample is emitted after release.

Test Plan:
- Post-reset: nco_valid=0, adc_valid=1 for 20 cycles -> out_valid stays 0, mix_active=0, all outputs 0.
- Gain/latency: nco_valid=1, adc=16384, cos=32767, sin=0, clken=1 -> out_valid rises 3 cycles after capture; i_o=65534, q_o=0, clip_o=0.
- Saturation: adc=-32768, cos=-32768, sin=-32768, neg_q=1 -> i_o=131071 with clip_o=1; q_o=-131072 (no clamp on Q); clip_cnt increments by 1 per such sample.
- clken gating: clken toggling 1,0,1,0 with a sample stream -> outputs advance only on enabled edges, data is unchanged, latency is 3 enabled cycles.
- Drain: drop nco_valid mid-stream -> the 3 in-flight samples still emerge, then out_valid=0; FSM goes to IDLE and mix_active=0; re-asserting nco_valid restarts RUN.
- Counter edges: force 65536 clipped samples -> clip_cnt holds 65535. Assert clr_clip coincident with a clip -> clip_cnt=0. Assert reset_n low mid-stream -> all outputs 0 asynchronously.
